demux4_dispatcher: RTL and testbench
====================================

// Module: demux4_dispatcher
// PURPOSE
//   Sequencer for the 1:4 demux datapath: accepts a stream of beats on a valid/ready input,
//   holds each beat in a one-entry register and drives the demux select plus per-output
//   valid until the addressed sink accepts. Sits between a single producer and four
//   consumers. Offers destination-addressed or round-robin dispatch and a stall timeout.
// PARAMETERS
//   DW       8   data width of din/dout
//   RR_MODE  0   0 = route by in_dest; 1 = round-robin 0->1->2->3->0, in_dest ignored
//   TIMEOUT  16  max stall cycles on a held beat before drop; 0 = never drop
// PORTS
//   clk        in   1    single clock, rising edge
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    producer has a beat
//   in_ready   out  1    dispatcher can take a beat this cycle
//   din        in   DW   input beat
//   in_dest    in   2    destination 0..3 (RR_MODE=0 only)
//   sel        out  2    demux select for the held beat
//   dout       out  DW   held beat, shared by all four outputs
//   out_valid  out  4    one-hot; bit sel high while a beat is held
//   out_ready  in   4    per-sink ready
//   err_drop   out  1    1-cycle pulse when a held beat is dropped on timeout
// BEHAVIOUR
//   - Reset (async assert): state=IDLE; sel=0, dout=0, out_valid=0, err_drop=0,
//     RR pointer=0, stall counter=0. in_ready=1 after reset release. A held beat is lost.
//   - FSM: IDLE (hold empty), BUSY (hold full).
//     IDLE: in_ready=1. in_valid=1 -> capture din, sel<=(RR_MODE ? ptr : in_dest),
//       ptr<=ptr+1 (mod 4, RR only), go to BUSY. Otherwise stay in IDLE.
//     BUSY: out_valid=4'b1 << sel. in_ready = out_ready[sel] (pass-through of the sink's ready).
//       Delivery happens when out_ready[sel]=1.
//       On delivery with in_valid=1: capture the next beat in the same cycle and stay
//         in BUSY (back-to-back, 1 beat/clk).
//       On delivery with in_valid=0: go to IDLE.
//       No delivery: stall counter +1.
//   - Latency: a beat accepted in cycle N is on dout/out_valid in cycle N+1.
//   - Ready from sinks other than sel is ignored. out_valid is never more than one-hot.
//   - Timeout (TIMEOUT>0): stall counter hits TIMEOUT in BUSY without delivery ->
//     drop the beat, err_drop=1 for one cycle, go to IDLE, in_ready=0 that cycle.
//     The RR pointer is not rewound. The counter clears on every capture and on every drop.
//   - sel/dout hold their last value in IDLE. Only out_valid is cleared.
//   - Counter width: clog2(TIMEOUT+1), min 1. The RR pointer wraps 3->0 naturally.
// CONFIGURATION
//   DEMUX4_STATS_EN defined: adds output port cnt_bus [63:0] holding four 16-bit saturating
//     delivered-beat counters, sink k at bits [16k+15:16k]. Reset to 0.
//     Counts are incremented on delivery and saturate at 16'hFFFF. Drops are not counted.
//   DEMUX4_STATS_EN undefined: no cnt_bus port and no counters. Behaviour is otherwise identical.
// TESTING
//   1 Reset: hold rst=1 mid-transfer -> out_valid=0, sel=0, dout=0, err_drop=0 asynchronously.
//     After release in_ready=1.
//   2 Addressed (RR_MODE=0): din=8'hA5, in_dest=2, all out_ready=1 -> next cycle sel=2,
//     out_valid=4'b0100, dout=8'hA5. Back-to-back dest 0,1,3 -> one delivery per cycle.
//   3 Round-robin (RR_MODE=1): 5 beats 8'h10..8'h14, any in_dest -> out_valid sequence
//     0001,0010,0100,1000,0001.
//   4 Backpressure: beat to dest 1, out_ready=4'b1101 for 3 cycles, then 4'b0010 ->
//     out_valid=0010 held and in_ready=0 for 3 cycles, delivered in cycle 4, dout stable.
//   5 Timeout (TIMEOUT=4): beat to dest 3, out_ready=0 -> err_drop pulses 4 cycles after
//     the beat appears. out_valid=0 and in_ready=0 in that cycle. in_ready=1 the next cycle.
//   6 Stats (DEMUX4_STATS_EN): 3 deliveries to sink 0, 1 to sink 2, 1 drop ->
//     cnt_bus = {16'd0,16'd1,16'd0,16'd3}.

Source files
------------

// File: rtl/demux4_dispatcher_if.sv
// rtl/demux4_dispatcher_if.sv - producer/consumer bus bundle for the 1:4 demux dispatcher
interface demux4_dispatcher_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] din;
  logic [1:0]    in_dest;
  logic [1:0]    sel;
  logic [DW-1:0] dout;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic          err_drop;

  modport master (
    output in_valid, din, in_dest, out_ready,
    input  in_ready, sel, dout, out_valid, err_drop
  );

  modport slave (
    input  in_valid, din, in_dest, out_ready,
    output in_ready, sel, dout, out_valid, err_drop
  );
endinterface

// File: rtl/demux4_dispatcher.sv
// rtl/demux4_dispatcher.sv - one-entry hold sequencer for a 1:4 demux with stall timeout
// Optional per-sink delivery counters on cnt_bus when DEMUX4_STATS_EN is defined.
module demux4_dispatcher #(
  parameter int DW      = 8,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  demux4_dispatcher_if.slave bus
`ifdef DEMUX4_STATS_EN
  ,
  output logic [63:0] cnt_bus
`endif
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] STALL_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [1:0]    sel_q, sel_nx;
  logic [1:0]    ptr_q, ptr_nx;
  logic [DW-1:0] data_q, data_nx;
  logic [CW-1:0] stall_q, stall_nx;
  logic          drop_q, drop_nx;
  logic          in_ready;
  logic          deliver;
  logic          take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      stall_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      sel_q   <= sel_nx;
      ptr_q   <= ptr_nx;
      data_q  <= data_nx;
      stall_q <= stall_nx;
      drop_q  <= drop_nx;
    end
  end

  // The drop cycle lands in IDLE but must refuse input, hence the drop_q gate.
  always_comb begin
    deliver  = (state == BUSY) && bus.out_ready[sel_q];
    in_ready = (state == BUSY) ? bus.out_ready[sel_q] : !drop_q;
    take     = bus.in_valid && in_ready;

    state_nx = state;
    sel_nx   = sel_q;
    ptr_nx   = ptr_q;
    data_nx  = data_q;
    stall_nx = stall_q;
    drop_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (take) state_nx = BUSY;
      end
      BUSY: begin
        if (deliver) begin
          state_nx = take ? BUSY : IDLE;
        end else if (TIMEOUT > 0) begin
          if (stall_q == STALL_LAST) begin
            state_nx = IDLE;
            drop_nx  = 1'b1;
            stall_nx = '0;
          end else begin
            stall_nx = stall_q + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (take) begin
      data_nx  = bus.din;
      sel_nx   = (RR_MODE != 0) ? ptr_q : bus.in_dest;
      stall_nx = '0;
      if (RR_MODE != 0) ptr_nx = ptr_q + 2'd1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.sel       = sel_q;
  assign bus.dout      = data_q;
  assign bus.out_valid = (state == BUSY) ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.err_drop  = drop_q;

`ifdef DEMUX4_STATS_EN
  logic [15:0] cnt_q [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= 16'd0;
    end else if (deliver && cnt_q[sel_q] != 16'hFFFF) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 16'd1;
    end
  end

  assign cnt_bus = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux4_dispatcher.sv
// tb/tb_demux4_dispatcher.sv - self-checking bench for demux4_dispatcher
module tb_demux4_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] dest = 2'd0;
  logic [3:0] ordy = 4'h0;

  demux4_dispatcher_if #(.DW(8)) ifa ();
  demux4_dispatcher_if #(.DW(8)) ifb ();
  demux4_dispatcher_if #(.DW(8)) ifc ();

  assign ifa.in_valid = iv;  assign ifa.din = din;  assign ifa.in_dest = dest;  assign ifa.out_ready = ordy;
  assign ifb.in_valid = iv;  assign ifb.din = din;  assign ifb.in_dest = dest;  assign ifb.out_ready = ordy;
  assign ifc.in_valid = iv;  assign ifc.din = din;  assign ifc.in_dest = dest;  assign ifc.out_ready = ordy;

`ifdef DEMUX4_STATS_EN
  logic [63:0] cnt_a, cnt_b, cnt_c;
`endif

  demux4_dispatcher #(.DW(8), .RR_MODE(0), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
`ifdef DEMUX4_STATS_EN
    , .cnt_bus(cnt_a)
`endif
  );
  demux4_dispatcher #(.DW(8), .RR_MODE(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
`ifdef DEMUX4_STATS_EN
    , .cnt_bus(cnt_b)
`endif
  );
  demux4_dispatcher #(.DW(8), .RR_MODE(1), .TIMEOUT(3)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc.slave)
`ifdef DEMUX4_STATS_EN
    , .cnt_bus(cnt_c)
`endif
  );

  int checks = 0;
  int errors = 0;

  // observed outputs per instance (0=a, 1=b, 2=c)
  logic        o_ir   [3];
  logic [3:0]  o_ov   [3];
  logic [1:0]  o_sel  [3];
  logic [7:0]  o_dout [3];
  logic        o_err  [3];
  logic [63:0] o_cnt  [3];

  // reference model: a held beat plus its age, per instance
  int         T   [3] = '{4, 0, 3};
  bit         RRM [3] = '{1'b0, 1'b1, 1'b1};
  bit         m_held  [3];
  logic [7:0] m_data  [3];
  logic [1:0] m_dest  [3];
  int         m_stall [3];
  int         m_ptr   [3];
  bit         m_drop  [3];
  int         m_cnt   [3][4];

  typedef struct {
    logic       iv;
    logic [7:0] din;
    logic [1:0] dest;
    logic [3:0] ordy;
    logic       ir;
    logic [3:0] ov;
    logic [1:0] sel;
    logic [7:0] dout;
    logic       err;
  } vec_t;

  vec_t       vt [21];
  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] sd [5] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample();
    o_ir[0] = ifa.in_ready; o_ov[0] = ifa.out_valid; o_sel[0] = ifa.sel; o_dout[0] = ifa.dout; o_err[0] = ifa.err_drop;
    o_ir[1] = ifb.in_ready; o_ov[1] = ifb.out_valid; o_sel[1] = ifb.sel; o_dout[1] = ifb.dout; o_err[1] = ifb.err_drop;
    o_ir[2] = ifc.in_ready; o_ov[2] = ifc.out_valid; o_sel[2] = ifc.sel; o_dout[2] = ifc.dout; o_err[2] = ifc.err_drop;
`ifdef DEMUX4_STATS_EN
    o_cnt[0] = cnt_a; o_cnt[1] = cnt_b; o_cnt[2] = cnt_c;
`else
    for (int k = 0; k < 3; k++) o_cnt[k] = 64'd0;
`endif
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] de, input logic [3:0] r);
    @(negedge clk);
    iv = v; din = d; dest = de; ordy = r;
    #1;
    sample();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iv = 1'b0; din = 8'h00; dest = 2'd0; ordy = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_held[k] = 1'b0; m_data[k] = 8'h00; m_dest[k] = 2'd0;
      m_stall[k] = 0; m_ptr[k] = 0; m_drop[k] = 1'b0;
      for (int s = 0; s < 4; s++) m_cnt[k][s] = 0;
    end
  endtask

  function automatic logic exp_ir(input int k);
    return m_held[k] ? ordy[m_dest[k]] : !m_drop[k];
  endfunction

  task automatic check_model(input int k);
    string t;
    t = $sformatf("rand dut%0d", k);
    chk({t, " in_ready"},  64'(o_ir[k]),   64'(exp_ir(k)));
    chk({t, " out_valid"}, 64'(o_ov[k]),   64'(m_held[k] ? (4'b0001 << m_dest[k]) : 4'b0000));
    chk({t, " sel"},       64'(o_sel[k]),  64'(m_dest[k]));
    chk({t, " dout"},      64'(o_dout[k]), 64'(m_data[k]));
    chk({t, " err_drop"},  64'(o_err[k]),  64'(m_drop[k]));
  endtask

  task automatic advance_model(input int k);
    logic ir, deliver, take;
    ir      = exp_ir(k);
    deliver = m_held[k] && ordy[m_dest[k]];
    take    = iv && ir;
    m_drop[k] = 1'b0;
    if (deliver) begin
      m_held[k] = 1'b0;
      if (m_cnt[k][m_dest[k]] < 65535) m_cnt[k][m_dest[k]]++;
    end else if (m_held[k]) begin
      m_stall[k]++;
      if (T[k] > 0 && m_stall[k] == T[k]) begin
        m_held[k] = 1'b0; m_drop[k] = 1'b1; m_stall[k] = 0;
      end
    end
    if (take) begin
      m_held[k] = 1'b1;
      m_data[k] = din;
      m_dest[k] = RRM[k] ? 2'(m_ptr[k]) : dest;
      if (RRM[k]) m_ptr[k] = (m_ptr[k] + 1) % 4;
      m_stall[k] = 0;
    end
  endtask

  initial begin
    //          iv    din    dest  ordy  | ir    ov    sel   dout   err
    vt[0]  = '{1'b1, 8'hA5, 2'd2, 4'hF,  1'b1, 4'h0, 2'd0, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 8'h11, 2'd0, 4'hF,  1'b1, 4'h4, 2'd2, 8'hA5, 1'b0};
    vt[2]  = '{1'b1, 8'h22, 2'd1, 4'hF,  1'b1, 4'h1, 2'd0, 8'h11, 1'b0};
    vt[3]  = '{1'b1, 8'h33, 2'd3, 4'hF,  1'b1, 4'h2, 2'd1, 8'h22, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 2'd0, 4'hF,  1'b1, 4'h8, 2'd3, 8'h33, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 2'd0, 4'hF,  1'b1, 4'h0, 2'd3, 8'h33, 1'b0};
    vt[6]  = '{1'b1, 8'h5C, 2'd1, 4'hF,  1'b1, 4'h0, 2'd3, 8'h33, 1'b0};
    vt[7]  = '{1'b1, 8'h77, 2'd0, 4'hD,  1'b0, 4'h2, 2'd1, 8'h5C, 1'b0};
    vt[8]  = '{1'b1, 8'h77, 2'd0, 4'hD,  1'b0, 4'h2, 2'd1, 8'h5C, 1'b0};
    vt[9]  = '{1'b1, 8'h77, 2'd0, 4'hD,  1'b0, 4'h2, 2'd1, 8'h5C, 1'b0};
    vt[10] = '{1'b0, 8'h00, 2'd0, 4'h2,  1'b1, 4'h2, 2'd1, 8'h5C, 1'b0};
    vt[11] = '{1'b0, 8'h00, 2'd0, 4'hF,  1'b1, 4'h0, 2'd1, 8'h5C, 1'b0};
    vt[12] = '{1'b1, 8'hE7, 2'd3, 4'h0,  1'b1, 4'h0, 2'd1, 8'h5C, 1'b0};
    vt[13] = '{1'b0, 8'h00, 2'd0, 4'h0,  1'b0, 4'h8, 2'd3, 8'hE7, 1'b0};
    vt[14] = '{1'b0, 8'h00, 2'd0, 4'h0,  1'b0, 4'h8, 2'd3, 8'hE7, 1'b0};
    vt[15] = '{1'b0, 8'h00, 2'd0, 4'h0,  1'b0, 4'h8, 2'd3, 8'hE7, 1'b0};
    vt[16] = '{1'b0, 8'h00, 2'd0, 4'h0,  1'b0, 4'h8, 2'd3, 8'hE7, 1'b0};
    vt[17] = '{1'b1, 8'h99, 2'd0, 4'h0,  1'b0, 4'h0, 2'd3, 8'hE7, 1'b1};
    vt[18] = '{1'b0, 8'h00, 2'd0, 4'h0,  1'b1, 4'h0, 2'd3, 8'hE7, 1'b0};
    vt[19] = '{1'b1, 8'h4B, 2'd2, 4'h4,  1'b1, 4'h0, 2'd3, 8'hE7, 1'b0};
    vt[20] = '{1'b0, 8'h00, 2'd0, 4'h4,  1'b1, 4'h4, 2'd2, 8'h4B, 1'b0};

    // asynchronous reset while a beat is held
    do_reset();
    drive(1'b1, 8'hC3, 2'd1, 4'h0);
    drive(1'b0, 8'h00, 2'd0, 4'h0);
    chk("rst pre out_valid", 64'(o_ov[0]), 64'(4'b0010));
    #2 rst = 1'b1;
    #1 sample();
    chk("rst out_valid", 64'(o_ov[0]), 64'(4'b0000));
    chk("rst sel", 64'(o_sel[0]), 64'(2'd0));
    chk("rst dout", 64'(o_dout[0]), 64'(8'h00));
    chk("rst err_drop", 64'(o_err[0]), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1 sample();
    chk("rst release in_ready", 64'(o_ir[0]), 64'(1'b1));

    // addressed dispatch, backpressure and timeout vectors on dut_a
    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(vt[i].iv, vt[i].din, vt[i].dest, vt[i].ordy);
      chk($sformatf("vec%0d in_ready", i),  64'(o_ir[0]),   64'(vt[i].ir));
      chk($sformatf("vec%0d out_valid", i), 64'(o_ov[0]),   64'(vt[i].ov));
      chk($sformatf("vec%0d sel", i),       64'(o_sel[0]),  64'(vt[i].sel));
      chk($sformatf("vec%0d dout", i),      64'(o_dout[0]), 64'(vt[i].dout));
      chk($sformatf("vec%0d err_drop", i),  64'(o_err[0]),  64'(vt[i].err));
    end

    // round-robin order ignores in_dest
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(i < 5, 8'(8'h10 + i), 2'($urandom), 4'hF);
      if (i > 0) begin
        chk($sformatf("rr%0d b out_valid", i), 64'(o_ov[1]),   64'(rr_exp[i-1]));
        chk($sformatf("rr%0d c out_valid", i), 64'(o_ov[2]),   64'(rr_exp[i-1]));
        chk($sformatf("rr%0d b dout", i),      64'(o_dout[1]), 64'(8'h10 + i - 1));
      end
    end

`ifdef DEMUX4_STATS_EN
    // three deliveries to sink 0, one to sink 2, one drop on sink 1
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(i), sd[i], 4'hF);
    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 2'd0, 4'h0);
    chk("stats cnt_bus", o_cnt[0], {16'd0, 16'd1, 16'd0, 16'd3});
`endif

    // randomized traffic against the reference model on all three instances
    do_reset();
    for (int c = 0; c < 800; c++) begin
      drive(($urandom % 4) != 0, 8'($urandom), 2'($urandom),
            (($urandom % 3) == 0) ? 4'h0 : 4'($urandom));
      for (int k = 0; k < 3; k++) begin
        check_model(k);
        advance_model(k);
      end
    end
`ifdef DEMUX4_STATS_EN
    drive(1'b0, 8'h00, 2'd0, 4'h0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("rand dut%0d cnt_bus", k), o_cnt[k],
          {16'(m_cnt[k][3]), 16'(m_cnt[k][2]), 16'(m_cnt[k][1]), 16'(m_cnt[k][0])});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
